// File: rtl/sseg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver_if
// Groups the display-value bus and the board-pin outputs of sseg_scan_driver.
//   iHex   [4*N-1:0]  digit values, nibble d = digit d, digit 0 = rightmost
//   iDP    [N-1:0]    decimal point per digit, 1 = lit
//   iBlank [N-1:0]    1 = digit dark for its whole slot
//   iLoad             1-cycle strobe, capture iHex/iDP/iBlank into pending
//   oSSeg  [7:0]      {A,B,C,D,E,F,G,DP}, active-low
//   oAnode [N-1:0]    anode enables, active-low, at most one low
//   oFrame            1-cycle pulse when the scan wraps to digit 0
// master = value producer / pin observer, slave = the scan driver.
// -----------------------------------------------------------------------------
interface sseg_scan_driver_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] iHex;
   logic [NUM_DIGITS-1:0]   iDP;
   logic [NUM_DIGITS-1:0]   iBlank;
   logic                    iLoad;
   logic [7:0]              oSSeg;
   logic [NUM_DIGITS-1:0]   oAnode;
   logic                    oFrame;

   modport master (
      output iHex, iDP, iBlank, iLoad,
      input  oSSeg, oAnode, oFrame
   );

   modport slave (
      input  iHex, iDP, iBlank, iLoad,
      output oSSeg, oAnode, oFrame
   );
endinterface

// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing
// one segment bus. A pending buffer captures the producer's value on iLoad; the
// shadow buffer that is actually displayed only takes the pending value at a
// frame boundary, so all digits change together. Each digit slot starts with
// BLANK_CYCLES of dead time (all anodes off) to suppress ghosting.
// Ports:
//   iClk    system clock, rising edge
//   iRst_n  asynchronous active-low reset
//   bus     sseg_scan_driver_if.slave (value inputs, segment/anode/frame outputs)
// -----------------------------------------------------------------------------
module sseg_scan_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic              iClk,
   input  logic              iRst_n,
   sseg_scan_driver_if.slave bus
);

   localparam int CNT_W = $clog2(DIGIT_CYCLES);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      SLOT_GAP,
      SLOT_DRIVE
   } slot_e;

   // Active-low A..G pattern for one hex nibble.
   function automatic logic [6:0] seg7(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // Scan position and buffers.
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    pend_q, pend_d;
   logic [4*NUM_DIGITS-1:0] pend_hex_q, pend_hex_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
   logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic [4*NUM_DIGITS-1:0] shd_hex_q, shd_hex_d;
   logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
   logic [NUM_DIGITS-1:0]   shd_blank_q, shd_blank_d;
   logic                    wrap;

   // Registered pin outputs.
   logic [7:0]              sseg_q, sseg_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic                    frame_q, frame_d;

   // Per-digit view of the next shadow value, selected by the next index.
   logic [3:0]              hex_arr [NUM_DIGITS];
   slot_e                   slot_d;
   logic                    lit_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_hex
         assign hex_arr[gi] = shd_hex_d[4*gi +: 4];
      end
   endgenerate

   // Counters and double buffer.
   always_comb begin
      cnt_d        = cnt_q + 1'b1;
      idx_d        = idx_q;
      wrap         = 1'b0;
      pend_d       = pend_q;
      pend_hex_d   = pend_hex_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      shd_hex_d    = shd_hex_q;
      shd_dp_d     = shd_dp_q;
      shd_blank_d  = shd_blank_q;

      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            wrap  = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end

      // Shadow takes the pending value as it stood before this edge; a load on
      // the same edge lands in pending and stays flagged for the next frame.
      if (wrap && pend_q) begin
         shd_hex_d   = pend_hex_q;
         shd_dp_d    = pend_dp_q;
         shd_blank_d = pend_blank_q;
         pend_d      = 1'b0;
      end

      if (bus.iLoad) begin
         pend_hex_d   = bus.iHex;
         pend_dp_d    = bus.iDP;
         pend_blank_d = bus.iBlank;
         pend_d       = 1'b1;
      end
   end

   // Outputs are computed from the next scan position so the registered pins
   // line up with cnt/idx without an extra pipeline stage. Every slot opens
   // with at least one GAP cycle, so an anode never switches off and another
   // switches on at the same edge.
   always_comb begin
      slot_d  = (cnt_d < CNT_BLANK) ? SLOT_GAP : SLOT_DRIVE;
      lit_d   = (slot_d == SLOT_DRIVE) && !shd_blank_d[idx_d];
      sseg_d  = 8'hFF;
      anode_d = '1;
      frame_d = wrap;
      if (lit_d) begin
         sseg_d         = {seg7(hex_arr[idx_d]), ~shd_dp_d[idx_d]};
         anode_d[idx_d] = 1'b0;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_q       <= 1'b0;
         pend_hex_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         shd_hex_q    <= '0;
         shd_dp_q     <= '0;
         shd_blank_q  <= '1;
         sseg_q       <= 8'hFF;
         anode_q      <= '1;
         frame_q      <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         pend_hex_q   <= pend_hex_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         shd_hex_q    <= shd_hex_d;
         shd_dp_q     <= shd_dp_d;
         shd_blank_q  <= shd_blank_d;
         sseg_q       <= sseg_d;
         anode_q      <= anode_d;
         frame_q      <= frame_d;
      end
   end

   assign bus.oSSeg  = sseg_q;
   assign bus.oAnode = anode_q;
   assign bus.oFrame = frame_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_driver
// Self-checking bench for sseg_scan_driver (4 digits, 8-clock slots, 2 dead
// clocks). A position-in-frame model predicts the pins every cycle; literal
// checks pin down specific segment codes and frame timing.
// -----------------------------------------------------------------------------
module tb_sseg_scan_driver;
   localparam int ND    = 4;
   localparam int DC    = 8;
   localparam int BC    = 2;
   localparam int FRAME = ND * DC;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   sseg_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

   sseg_scan_driver #(
      .NUM_DIGITS  (ND),
      .DIGIT_CYCLES(DC),
      .BLANK_CYCLES(BC)
   ) dut (
      .iClk  (clk),
      .iRst_n(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Active-low A..G codes for hex 0..F.
   logic [6:0] seg_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   int vectors = 0;
   int errors  = 0;

   // Behavioural model: position within the frame plus the two buffers.
   int          m_pos;
   logic        m_frame;
   logic        m_pend;
   logic [15:0] m_phex, m_shex;
   logic [3:0]  m_pdp, m_pblank, m_sdp, m_sblank;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos    <= 0;
         m_frame  <= 1'b0;
         m_pend   <= 1'b0;
         m_phex   <= '0;
         m_pdp    <= '0;
         m_pblank <= '0;
         m_shex   <= '0;
         m_sdp    <= '0;
         m_sblank <= '1;
      end else begin
         m_pos   <= (m_pos + 1) % FRAME;
         m_frame <= (m_pos == FRAME - 1);
         if (m_pos == FRAME - 1 && m_pend) begin
            m_shex   <= m_phex;
            m_sdp    <= m_pdp;
            m_sblank <= m_pblank;
            m_pend   <= 1'b0;
         end
         if (bus.iLoad) begin
            m_phex   <= bus.iHex;
            m_pdp    <= bus.iDP;
            m_pblank <= bus.iBlank;
            m_pend   <= 1'b1;
         end
      end
   end

   function automatic void model_out(output logic [7:0] s, output logic [3:0] a);
      int         d;
      int         c;
      logic [3:0] h;
      d = m_pos / DC;
      c = m_pos % DC;
      s = 8'hFF;
      a = 4'hF;
      if (c >= BC && !m_sblank[d]) begin
         h = m_shex[4*d +: 4];
         s = {seg_tab[h], ~m_sdp[d]};
         a = ~(4'b0001 << d);
      end
   endfunction

   // Every-cycle compare against the model, plus the one-anode rule.
   always @(negedge clk) begin
      logic [7:0] es;
      logic [3:0] ea;
      model_out(es, ea);
      vectors++;
      if (bus.oSSeg !== es || bus.oAnode !== ea || bus.oFrame !== m_frame) begin
         errors++;
         $display("FAIL cycle pos=%0d sseg=%h want %h anode=%b want %b frame=%b want %b",
                  m_pos, bus.oSSeg, es, bus.oAnode, ea, bus.oFrame, m_frame);
      end
      vectors++;
      if ($countones(~bus.oAnode) > 1) begin
         errors++;
         $display("FAIL anode_onehot anode=%b want at most one low", bus.oAnode);
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end else begin
         $display("ok   %s = %h", name, act);
      end
   endtask

   // Advance to the next negedge at which the model sits at position tgt.
   task automatic wait_pos(input int tgt);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_pos != tgt && n < 4 * FRAME);
      vectors++;
      if (m_pos != tgt) begin
         errors++;
         $display("FAIL wait_pos timeout pos=%0d want %0d", m_pos, tgt);
      end
   endtask

   // Called at a negedge; the strobe covers exactly the following posedge.
   task automatic load(input logic [15:0] h, input logic [3:0] dp, input logic [3:0] bl);
      bus.iHex   = h;
      bus.iDP    = dp;
      bus.iBlank = bl;
      bus.iLoad  = 1'b1;
      $display("load hex=%h dp=%b blank=%b at pos=%0d", h, dp, bl, m_pos);
      @(negedge clk);
      bus.iLoad  = 1'b0;
   endtask

   initial begin
      int         first_frame;
      logic [3:0] h4;
      logic       dpb;
      logic [15:0] rh;
      logic [3:0]  rd, rb;

      bus.iHex   = '0;
      bus.iDP    = '0;
      bus.iBlank = '0;
      bus.iLoad  = 1'b0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset_sseg", bus.oSSeg, 8'hFF);
      chk("reset_anode", {4'h0, bus.oAnode}, 8'h0F);
      chk("reset_frame", {7'h0, bus.oFrame}, 8'h00);
      rst_n = 1'b1;

      // Idle for two frames; first frame pulse after 32 clocks.
      first_frame = -1;
      for (int n = 1; n <= 2 * FRAME; n++) begin
         @(negedge clk);
         if (bus.oFrame && first_frame < 0) first_frame = n;
      end
      chk("first_frame_cycle", 8'(first_frame), 8'd32);

      // 1234 with DP on digit 0.
      @(negedge clk);
      load(16'h1234, 4'b0001, 4'b0000);
      wait_pos(0);
      chk("t2_gap_sseg", bus.oSSeg, 8'hFF);
      chk("t2_frame", {7'h0, bus.oFrame}, 8'h01);
      wait_pos(3);
      chk("t2_d0_sseg", bus.oSSeg, 8'h98);
      chk("t2_d0_anode", {4'h0, bus.oAnode}, 8'h0E);
      wait_pos(DC + 2);
      chk("t2_d1_sseg", bus.oSSeg, 8'h0D);
      chk("t2_d1_anode", {4'h0, bus.oAnode}, 8'h0D);
      wait_pos(2 * DC + 5);
      chk("t2_d2_sseg", bus.oSSeg, 8'h25);
      chk("t2_d2_anode", {4'h0, bus.oAnode}, 8'h0B);

      // 0808 with digits 1 and 3 blanked.
      load(16'h0808, 4'b0000, 4'b1010);
      wait_pos(0);
      wait_pos(4);
      chk("t3_d0_sseg", bus.oSSeg, 8'h01);
      wait_pos(DC + 4);
      chk("t3_d1_anode", {4'h0, bus.oAnode}, 8'h0F);
      wait_pos(2 * DC + 4);
      chk("t3_d2_anode", {4'h0, bus.oAnode}, 8'h0B);
      wait_pos(3 * DC + 4);
      chk("t3_d3_sseg", bus.oSSeg, 8'hFF);

      // Two loads in one frame: current frame unchanged, last load wins.
      wait_pos(5);
      load(16'h1111, 4'b0000, 4'b0000);
      wait_pos(20);
      load(16'h2222, 4'b0000, 4'b0000);
      wait_pos(2 * DC + 6);
      chk("t4_unchanged", bus.oSSeg, 8'h01);
      wait_pos(0);
      wait_pos(3);
      chk("t4_last_wins", bus.oSSeg, 8'h25);

      // Load on the frame-boundary edge while a load is already pending.
      wait_pos(10);
      load(16'h5555, 4'b0000, 4'b0000);
      wait_pos(FRAME - 1);
      load(16'h6666, 4'b0000, 4'b0000);
      chk("t5_frame_hi", {7'h0, bus.oFrame}, 8'h01);
      @(negedge clk);
      chk("t5_frame_lo", {7'h0, bus.oFrame}, 8'h00);
      wait_pos(3);
      chk("t5_old_pending", bus.oSSeg, 8'h49);
      wait_pos(0);
      wait_pos(3);
      chk("t5_new_value", bus.oSSeg, 8'h41);

      // Asynchronous reset in the middle of a driven slot.
      wait_pos(5);
      chk("t1_lit_before_rst", bus.oSSeg, 8'h41);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_sseg", bus.oSSeg, 8'hFF);
      chk("async_rst_anode", {4'h0, bus.oAnode}, 8'h0F);
      chk("async_rst_frame", {7'h0, bus.oFrame}, 8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Every hex code with DP on and off through digit 0.
      for (int i = 0; i < 32; i++) begin
         h4  = 4'(i >> 1);
         dpb = 1'(i & 1);
         rh  = 16'($urandom);
         rd  = 4'($urandom);
         rb  = 4'($urandom);
         @(negedge clk);
         load({rh[15:4], h4}, {rd[3:1], dpb}, {rb[3:1], 1'b0});
         wait_pos(0);
         wait_pos(3);
         chk($sformatf("t6_hex%h_dp%0d", h4, dpb), bus.oSSeg, {seg_tab[h4], ~dpb});
      end

      // Random loads at random times, some aimed at the frame boundary.
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            wait_pos(FRAME - 1);
         end else begin
            repeat ($urandom_range(1, 40)) @(negedge clk);
         end
         load(16'($urandom), 4'($urandom), 4'($urandom));
      end
      repeat (2 * FRAME) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
